instr_queue: RTL and testbench
==============================

Name: instr_queue

Overview:
- Instruction prefetch queue between the fetch stage and the decode stage of the 16-bit core.
- Buffers fetched instruction words with their PC so decode stalls do not lose fetched words.
- Its in_ready drives the fetch stage PC-advance control.
- On a branch or jump it flushes all queued entries.

Parameters:
- DEPTH, 4, number of queue entries; must be a power of two, at least 2.
- ADDR_W, 8, width of the PC tag stored with each instruction.
- NOP_INSTR, 16'h0000, value driven on out_instr while the queue is empty.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  the fetch stage presents a valid instruction this cycle.
- in_instr  input  16  instruction word from the fetch stage.
- in_pc  input  ADDR_W  PC of in_instr.
- in_ready  output  1  queue can accept a word this cycle; low holds the PC.
- flush  input  1  discard all entries (taken branch or jump).
- out_valid  output  1  head entry is valid.
- out_instr  output  16  head instruction word.
- out_pc  output  ADDR_W  PC of the head instruction.
- out_ready  input  1  decode consumes the head this cycle.
- count  output  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Storage:
  - DEPTH x (16+ADDR_W) circular buffer.
  - Write pointer and read pointer, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy counter, 0..DEPTH.
- Write: occurs when in_valid && in_ready at the rising edge. Stores {in_instr, in_pc} at wr_ptr, then wr_ptr+1.
- Read: occurs when out_valid && out_ready. rd_ptr+1.
- Handshake signals:
  - in_ready = (count != DEPTH). Combinational from registered count only, with no dependence on out_ready in the same cycle.
  - out_valid = (count != 0).
  - out_instr/out_pc = entry at rd_ptr when out_valid. When empty, out_instr = NOP_INSTR and out_pc = 0.
- Latency: a word written at edge N is visible on out_* after edge N. There is no same-cycle bypass.
- Simultaneous read and write (count neither 0 nor DEPTH): both pointers advance and count is unchanged.
- Full: in_ready=0, so no write that cycle even if a read occurs. in_ready rises in the cycle after the read.
- Empty: out_valid=0. out_ready is ignored and the pointers do not move.
- in_valid while in_ready=0: ignored. The producer must hold the word.
- Flush:
  - At the edge with flush=1: wr_ptr=rd_ptr=0 and count=0.
  - Any same-cycle write or read is discarded.
  - The next cycle shows out_valid=0, in_ready=1.
- Priority: reset > flush > read/write.
- Reset values: out_valid=0, in_ready=1, count=0, out_instr=NOP_INSTR, out_pc=0, both pointers 0. Storage contents are don't-care.
- Reset mid-operation: queued entries are lost. Same outcome as a flush.
- count is always equal to wr_ptr-rd_ptr modulo DEPTH, except it reads DEPTH when full.

Test Plan:
- Reset then idle: assert reset 2 cycles and release → out_valid=0, in_ready=1, count=0, out_instr=16'h0000.
- Ordered fill and drain:
  - Write 16'h1111@pc0, 16'h2222@pc1, 16'h3333@pc2 with out_ready=0 → count=3, out_instr=16'h1111, out_pc=0.
  - Then raise out_ready → words emerge 1111, 2222, 3333 on consecutive cycles, then out_valid=0.
- Full boundary (DEPTH=4):
  - Write 5 words with out_ready=0 → count=4, in_ready=0, and the fifth word is not stored.
  - Pulse out_ready one cycle → in_ready=1 on the next cycle, and the fifth word is accepted after the producer re-presents it.
- Simultaneous read/write with wrap-around:
  - Stream 10 words with in_valid=1 and out_ready=1 held from count=2.
  - Expected: count stays at 2, and the pointers wrap past index 3.
  - Output order matches input order and PCs match.
- Flush with concurrent write:
  - With count=3, assert flush together with in_valid=1 and in_instr=16'hABCD.
  - Expected next cycle: count=0, out_valid=0, and 16'hABCD is never output.
- Reset with concurrent flush and write:
  - With count=2, assert reset, flush and in_valid together.
  - Expected: reset values as above, and the queue is empty afterwards.

Source files
------------

// File: rtl/instr_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction prefetch queue.
// The master modport is the fetch/decode side; the slave modport is the queue itself.
interface instr_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic [15:0]       in_instr;
    logic [ADDR_W-1:0] in_pc;
    logic              in_ready;
    logic              flush;
    logic              out_valid;
    logic [15:0]       out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic              out_ready;
    logic [CNT_W-1:0]  count;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, count
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_instr, out_pc, count
    );
endinterface

// File: rtl/instr_queue.sv
// Instruction prefetch queue: circular buffer of {instr, pc} between fetch and decode.
// A flush (taken branch/jump) empties it; there is no write-to-read bypass.
module instr_queue #(
    parameter int          DEPTH     = 4,
    parameter int          ADDR_W    = 8,
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic         clock,
    input  logic         reset,
    instr_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [15:0]       instr;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  occupancy;
    logic              full;
    logic              empty;
    logic              do_write;
    logic              do_read;

    // Handshake is derived from the registered occupancy only, so in_ready never depends on out_ready.
    assign full     = (occupancy == CNT_W'(DEPTH));
    assign empty    = (occupancy == '0);
    assign do_write = bus.in_valid && !full;
    assign do_read  = bus.out_ready && !empty;

    always_ff @(posedge clock) begin
        if (reset || bus.flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_write, do_read})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Storage is not reset; entries are only observable through rd_ptr while occupancy is non-zero.
    always_ff @(posedge clock) begin
        if (!reset && !bus.flush && do_write) begin
            mem[wr_ptr] <= '{instr: bus.in_instr, pc: bus.in_pc};
        end
    end

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_instr = empty ? NOP_INSTR : mem[rd_ptr].instr;
    assign bus.out_pc    = empty ? '0 : mem[rd_ptr].pc;
    assign bus.count     = occupancy;
endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue (DEPTH=4, ADDR_W=8).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_instr_queue;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 8;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fails;

    instr_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

    instr_queue #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .NOP_INSTR(16'h0000)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_stimulus(input logic valid, input logic [15:0] instr,
                                  input logic [7:0] pc, input logic rdy, input logic flsh);
        bus.in_valid  = valid;
        bus.in_instr  = instr;
        bus.in_pc     = pc;
        bus.out_ready = rdy;
        bus.flush     = flsh;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_head(input string tag, input logic [15:0] instr, input logic [7:0] pc);
        check_output({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check_output({tag, "_instr"}, 32'(bus.out_instr), 32'(instr));
        check_output({tag, "_pc"},    32'(bus.out_pc),    32'(pc));
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check_output({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
        check_output({tag, "_count"},     32'(bus.count),     32'd0);
        check_output({tag, "_out_instr"}, 32'(bus.out_instr), 32'h0000);
        check_output({tag, "_out_pc"},    32'(bus.out_pc),    32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b1;
        apply_stimulus(1'b0, 16'h0000, 8'd0, 1'b0, 1'b0);

        // Reset then idle
        tick();
        tick();
        reset = 1'b0;
        check_idle("reset");
        tick();
        check_idle("idle");

        // Ordered fill and drain; the first word must not bypass to the output
        apply_stimulus(1'b1, 16'h1111, 8'd0, 1'b0, 1'b0);
        check_output("no_bypass", 32'(bus.out_valid), 32'd0);
        tick();
        check_output("fill_count1", 32'(bus.count), 32'd1);
        check_head("fill_head1", 16'h1111, 8'd0);
        apply_stimulus(1'b1, 16'h2222, 8'd1, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b1, 16'h3333, 8'd2, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 16'h0000, 8'd0, 1'b0, 1'b0);
        check_output("fill_count3", 32'(bus.count), 32'd3);
        check_head("fill_head3", 16'h1111, 8'd0);
        apply_stimulus(1'b0, 16'h0000, 8'd0, 1'b1, 1'b0);
        check_head("drain0", 16'h1111, 8'd0);
        tick();
        check_head("drain1", 16'h2222, 8'd1);
        tick();
        check_head("drain2", 16'h3333, 8'd2);
        tick();
        check_idle("drained");
        tick();
        check_idle("empty_read_ignored");

        // Full boundary: fifth word is refused until a read frees a slot
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, 16'hA000 + 16'(i), 8'(10 + i), 1'b0, 1'b0);
            tick();
        end
        check_output("full_count", 32'(bus.count), 32'd4);
        check_output("full_in_ready", 32'(bus.in_ready), 32'd0);
        check_head("full_head", 16'hA000, 8'd10);
        apply_stimulus(1'b1, 16'hA004, 8'd14, 1'b1, 1'b0);
        tick();
        check_output("pop_count", 32'(bus.count), 32'd3);
        check_output("pop_in_ready", 32'(bus.in_ready), 32'd1);
        check_head("pop_head", 16'hA001, 8'd11);
        apply_stimulus(1'b1, 16'hA004, 8'd14, 1'b0, 1'b0);
        tick();
        check_output("refill_count", 32'(bus.count), 32'd4);
        apply_stimulus(1'b0, 16'h0000, 8'd0, 1'b1, 1'b0);
        for (int i = 1; i < 5; i++) begin
            check_head($sformatf("full_drain%0d", i), 16'hA000 + 16'(i), 8'(10 + i));
            tick();
        end
        check_idle("full_drained");

        // Simultaneous read/write with pointer wrap-around
        apply_stimulus(1'b1, 16'hB000, 8'd20, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b1, 16'hB001, 8'd21, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 10; k++) begin
            apply_stimulus(1'b1, 16'hB002 + 16'(k), 8'(22 + k), 1'b1, 1'b0);
            check_output($sformatf("stream_count%0d", k), 32'(bus.count), 32'd2);
            check_head($sformatf("stream%0d", k), 16'hB000 + 16'(k), 8'(20 + k));
            tick();
        end
        check_output("stream_count_end", 32'(bus.count), 32'd2);
        apply_stimulus(1'b0, 16'h0000, 8'd0, 1'b1, 1'b0);
        check_head("stream_tail0", 16'hB00A, 8'd30);
        tick();
        check_head("stream_tail1", 16'hB00B, 8'd31);
        tick();
        check_idle("stream_drained");

        // Flush with concurrent write (and read) discards everything
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 16'hC000 + 16'(i), 8'(40 + i), 1'b0, 1'b0);
            tick();
        end
        check_output("preflush_count", 32'(bus.count), 32'd3);
        apply_stimulus(1'b1, 16'hABCD, 8'd99, 1'b1, 1'b1);
        tick();
        apply_stimulus(1'b0, 16'h0000, 8'd0, 1'b0, 1'b0);
        check_idle("flush");
        tick();
        check_idle("flush_no_abcd");
        apply_stimulus(1'b1, 16'hD000, 8'd50, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 16'h0000, 8'd0, 1'b0, 1'b0);
        check_output("postflush_count", 32'(bus.count), 32'd1);
        check_head("postflush_head", 16'hD000, 8'd50);

        // Reset with concurrent flush and write
        apply_stimulus(1'b1, 16'hD001, 8'd51, 1'b0, 1'b0);
        tick();
        check_output("prereset_count", 32'(bus.count), 32'd2);
        apply_stimulus(1'b1, 16'hEEEE, 8'd77, 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        apply_stimulus(1'b0, 16'h0000, 8'd0, 1'b0, 1'b0);
        check_idle("reset_mid");
        tick();
        check_idle("reset_mid_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
